cw_mux_sel_ctrl: RTL and testbench

//  Generates the one-hot 3-way select (100/010/001) that drives the CW_Mux31 display-path muxes.

---
 rtl/cw_mux_sel_ctrl_if.sv | 11 +
 rtl/cw_mux_sel_ctrl.sv | 78 +++++++
 tb/tb_cw_mux_sel_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/cw_mux_sel_ctrl_if.sv
// cw_mux_sel_ctrl_if: button, tick and auto-scan inputs plus the one-hot select outputs of cw_mux_sel_ctrl
interface cw_mux_sel_ctrl_if;
  logic       btn_next;
  logic       btn_prev;
  logic       tick_1hz;
  logic       auto_scan;
  logic [2:0] sel;
  logic       sel_changed;
  modport master (output btn_next, btn_prev, tick_1hz, auto_scan, input sel, sel_changed);
  modport slave (input btn_next, btn_prev, tick_1hz, auto_scan, output sel, sel_changed);
endinterface

// File: rtl/cw_mux_sel_ctrl.sv
// cw_mux_sel_ctrl: debounced next/prev buttons and 1 Hz auto-scan driving a one-hot 3-way display select
module cw_mux_sel_ctrl #(
  parameter int DEBOUNCE_CYC = 270000,
  parameter int SCAN_SEC     = 5,
  parameter int CNT_W        = 20
) (
  input logic              clk_i,
  input logic              rst_ni,
  cw_mux_sel_ctrl_if.slave bus_io
);
  localparam int SCAN_W = $clog2(SCAN_SEC + 1);
  localparam logic [2:0] SEL_A = 3'b100;
  localparam logic [2:0] SEL_B = 3'b010;
  localparam logic [2:0] SEL_C = 3'b001;
  logic [1:0]        sync1_q, sync2_q, press;
  logic [2:0]        sel_q, sel_d, sel_fwd, sel_bwd;
  logic              sel_changed_q, sel_changed_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic              illegal, manual, scan_step;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {bus_io.btn_prev, bus_io.btn_next};
      sync2_q <= sync1_q;
    end
  end
  // bit 0 = next, bit 1 = prev
  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d, stable_prev_q, diff, done;
    always_comb begin
      diff     = sync2_q[i] != stable_q;
      done     = diff && (cnt_q == CNT_W'(DEBOUNCE_CYC - 1));
      cnt_d    = (diff && !done) ? cnt_q + 1'b1 : '0;
      stable_d = done ? sync2_q[i] : stable_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q         <= '0;
        stable_q      <= 1'b0;
        stable_prev_q <= 1'b0;
      end else begin
        cnt_q         <= cnt_d;
        stable_q      <= stable_d;
        stable_prev_q <= stable_q;
      end
    end
    assign press[i] = stable_q & ~stable_prev_q;
  end
  // a cancelled next&prev still counts as manual activity and restarts the scan interval
  always_comb begin
    sel_fwd       = {sel_q[0], sel_q[2:1]};
    sel_bwd       = {sel_q[1:0], sel_q[2]};
    illegal       = !(sel_q inside {SEL_A, SEL_B, SEL_C});
    manual        = |press;
    scan_step     = bus_io.auto_scan && bus_io.tick_1hz && (scan_cnt_q == SCAN_W'(SCAN_SEC - 1));
    sel_d         = illegal ? SEL_A : (&press) ? sel_q : press[0] ? sel_fwd :
                    press[1] ? sel_bwd : scan_step ? sel_fwd : sel_q;
    sel_changed_d = sel_d != sel_q;
    scan_cnt_d    = (illegal || manual || !bus_io.auto_scan || scan_step) ? '0 :
                    bus_io.tick_1hz ? scan_cnt_q + 1'b1 : scan_cnt_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_q         <= SEL_A;
      sel_changed_q <= 1'b0;
      scan_cnt_q    <= '0;
    end else begin
      sel_q         <= sel_d;
      sel_changed_q <= sel_changed_d;
      scan_cnt_q    <= scan_cnt_d;
    end
  end
  assign bus_io.sel         = sel_q;
  assign bus_io.sel_changed = sel_changed_q;
endmodule

// File: tb/tb_cw_mux_sel_ctrl.sv
// tb_cw_mux_sel_ctrl: directed cycle-by-cycle vectors for cw_mux_sel_ctrl with DEBOUNCE_CYC=4, SCAN_SEC=3
module tb_cw_mux_sel_ctrl;
  typedef struct packed {
    logic       rst;
    logic       nx;
    logic       pv;
    logic       tk;
    logic       au;
    logic [7:0] rep;
    logic [2:0] sel;
    logic       chg;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vecs[$];
  logic [2:0] scan_seq [9] = '{3'b100, 3'b100, 3'b010, 3'b010, 3'b010, 3'b001, 3'b001, 3'b001, 3'b100};

  cw_mux_sel_ctrl_if bus ();
  cw_mux_sel_ctrl #(.DEBOUNCE_CYC(4), .SCAN_SEC(3), .CNT_W(4)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus_io(bus.slave)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic r, n, p, t, a, input int rep, input logic [2:0] s, input logic c);
    return '{rst: r, nx: n, pv: p, tk: t, au: a, rep: 8'(rep), sel: s, chg: c};
  endfunction

  task automatic check(input string name, input logic [2:0] s, input logic c);
    n_vec++;
    if (bus.sel !== s || bus.sel_changed !== c) begin
      n_bad++;
      $display("FAIL %s: got sel=%b chg=%b, expected sel=%b chg=%b", name, bus.sel, bus.sel_changed, s, c);
    end
  endtask

  task automatic drive(input logic n, p, t, a);
    bus.btn_next  = n;
    bus.btn_prev  = p;
    bus.tick_1hz  = t;
    bus.auto_scan = a;
  endtask

  // entered and left at 1 time unit after a rising edge; reset asserts mid-cycle
  task automatic do_reset();
    drive(0, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1 check("async_reset", 3'b100, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic force_sel(input logic [2:0] bad);
    #2 force dut.sel_q = bad;
    #1 release dut.sel_q;
    @(posedge clk);
    #1 check($sformatf("recover_%b", bad), 3'b100, 1'b1);
    @(posedge clk);
    #1 check($sformatf("recover_%b_hold", bad), 3'b100, 1'b0);
  endtask

  initial begin
    drive(0, 0, 0, 0);
    @(posedge clk);
    #1;
    // next press held 20 cycles: step at edge 7, nothing on release
    vecs.push_back(v(1, 1, 0, 0, 0, 6, 3'b100, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 1, 3'b010, 1));
    vecs.push_back(v(0, 1, 0, 0, 0, 13, 3'b010, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 10, 3'b010, 0));
    // 3-cycle glitch is rejected
    vecs.push_back(v(0, 1, 0, 0, 0, 3, 3'b010, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 10, 3'b010, 0));
    // reset from 010, then three prev presses
    vecs.push_back(v(1, 0, 1, 0, 0, 6, 3'b100, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 1, 3'b001, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 8, 3'b001, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 6, 3'b001, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 1, 3'b010, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 8, 3'b010, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 6, 3'b010, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 1, 3'b100, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 8, 3'b100, 0));
    // next and prev together cancel
    vecs.push_back(v(0, 1, 1, 0, 0, 12, 3'b100, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 8, 3'b100, 0));
    // auto-scan: step on ticks 3, 6, 9
    for (int t = 0; t < 9; t++) begin
      vecs.push_back(v(0, 0, 0, 1, 1, 1, scan_seq[t], (t % 3) == 2));
      vecs.push_back(v(0, 0, 0, 0, 1, 3, scan_seq[t], 0));
    end
    // manual next between ticks 2 and 3 restarts the scan interval
    vecs.push_back(v(1, 0, 0, 1, 1, 1, 3'b100, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 3, 3'b100, 0));
    vecs.push_back(v(0, 0, 0, 1, 1, 1, 3'b100, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 3, 3'b100, 0));
    vecs.push_back(v(0, 1, 0, 0, 1, 6, 3'b100, 0));
    vecs.push_back(v(0, 1, 0, 0, 1, 1, 3'b010, 1));
    vecs.push_back(v(0, 0, 0, 0, 1, 8, 3'b010, 0));
    vecs.push_back(v(0, 0, 0, 1, 1, 1, 3'b010, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 3, 3'b010, 0));
    vecs.push_back(v(0, 0, 0, 1, 1, 1, 3'b010, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 3, 3'b010, 0));
    vecs.push_back(v(0, 0, 0, 1, 1, 1, 3'b001, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 3, 3'b001, 0));

    for (int k = 0; k < vecs.size(); k++) begin
      if (vecs[k].rst) do_reset();
      drive(vecs[k].nx, vecs[k].pv, vecs[k].tk, vecs[k].au);
      for (int r = 0; r < int'(vecs[k].rep); r++) begin
        @(posedge clk);
        #1 check($sformatf("vec%0d_cyc%0d", k, r), vecs[k].sel, vecs[k].chg);
        if (vecs[k].tk) bus.tick_1hz = 1'b0;
      end
    end

    // corrupted select recovers to 100
    force_sel(3'b011);
    force_sel(3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
